// File: rtl/depack_pkg.sv
// Shared definitions for the frame depacketiser: default header bytes,
// checksum mode encodings, FSM state encoding and the checksum step.
package depack_pkg;

  localparam logic [7:0] DEF_HDR0 = 8'hEB;
  localparam logic [7:0] DEF_HDR1 = 8'h90;

  localparam int CSUM_ADD = 0;
  localparam int CSUM_XOR = 1;

  typedef enum logic [1:0] {
    ST_RX,
    ST_HDR,
    ST_SUM,
    ST_CMP
  } state_e;

  // Carries are discarded: the 8-bit result of acc + b wraps modulo 256.
  function automatic logic [7:0] csum_step(input int mode, input logic [7:0] acc,
                                           input logic [7:0] b);
    return (mode == CSUM_XOR) ? (acc ^ b) : (acc + b);
  endfunction

endpackage

// File: rtl/frame_cksum.sv
// 8-bit checksum accumulator: clear, then fold one byte per enabled cycle
// using modulo-256 add or XOR depending on MODE.
module frame_cksum
  import depack_pkg::*;
#(
  parameter int MODE = CSUM_ADD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum
);

  logic [7:0] r_acc;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= csum_step(MODE, r_acc, i_byte);
  end

  assign o_sum = r_acc;

endmodule

// File: rtl/frame_depack_p.sv
// Byte-stream frame depacketiser: sliding-window header search, serial
// checksum verification, and a single-entry published frame with overrun flag.
module frame_depack_p
  import depack_pkg::*;
#(
  parameter int         FRAME_LEN = 42,
  parameter logic [7:0] HDR0      = DEF_HDR0,
  parameter logic [7:0] HDR1      = DEF_HDR1,
  parameter int         CSUM_MODE = CSUM_ADD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   load,
  output logic                   frame_ready,
  output logic [8*FRAME_LEN-1:0] frame_data,
  output logic                   crc_err,
  output logic                   overrun,
  output logic [15:0]            good_cnt,
  output logic [15:0]            err_cnt
);

  localparam int              CW        = $clog2(FRAME_LEN + 1);
  localparam int              WW        = 8 * FRAME_LEN;
  localparam logic [CW-1:0]   FILL_FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0]   FILL_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]   FILL_ONE  = CW'(1);
  localparam logic [CW-1:0]   IDX_FIRST = CW'(2);
  localparam logic [CW-1:0]   IDX_LAST  = CW'(FRAME_LEN - 2);

  state_e          r_state, w_next;
  logic [WW-1:0]   r_win;
  logic [CW-1:0]   r_fill;
  logic [CW-1:0]   r_idx;
  logic            w_accept, w_hdr_ok, w_match, w_publish;
  logic            w_sum_clr, w_sum_en;
  logic [7:0]      w_sum_byte, w_sum;

  // Window byte k lives at [8*(FRAME_LEN-1-k) +: 8], the same layout as frame_data.
  assign in_ready   = (r_state == ST_RX);
  assign w_accept   = in_valid && in_ready;
  assign w_hdr_ok   = (r_win[WW-1 -: 8] == HDR0) && (r_win[WW-9 -: 8] == HDR1);
  assign w_sum_byte = r_win[8*(FRAME_LEN-1-int'(r_idx)) +: 8];
  assign w_match    = (w_sum == r_win[7:0]);
  assign w_publish  = (r_state == ST_CMP) && w_match;

  frame_cksum #(
    .MODE(CSUM_MODE)
  ) u_cksum (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_sum_clr),
    .i_en  (w_sum_en),
    .i_byte(w_sum_byte),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RX;
    else      r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_sum_clr = 1'b0;
    w_sum_en  = 1'b0;
    case (r_state)
      ST_RX:  if (r_fill == FILL_FULL || (w_accept && r_fill == FILL_LAST)) w_next = ST_HDR;
      ST_HDR: begin
        w_next    = w_hdr_ok ? ST_SUM : ST_RX;
        w_sum_clr = w_hdr_ok;
      end
      ST_SUM: begin
        w_sum_en = 1'b1;
        if (r_idx == IDX_LAST) w_next = ST_CMP;
      end
      ST_CMP:  w_next = ST_RX;
      default: w_next = ST_RX;
    endcase
  end

  // NOTE: the window and published frame are plain registers, not RAM, so
  // they take the async reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win       <= '0;
      r_fill      <= '0;
      r_idx       <= '0;
      frame_data  <= '0;
      frame_ready <= 1'b0;
      crc_err     <= 1'b0;
      overrun     <= 1'b0;
      good_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_win <= {r_win[WW-9:0], in_data};
        if (r_fill != FILL_FULL) r_fill <= r_fill + FILL_ONE;
      end

      case (r_state)
        ST_HDR: begin
          if (w_hdr_ok) r_idx  <= IDX_FIRST;
          else          r_fill <= FILL_LAST;
        end
        ST_SUM: r_idx <= r_idx + FILL_ONE;
        ST_CMP: begin
          if (w_match) begin
            frame_data <= r_win;
            crc_err    <= 1'b0;
            r_fill     <= '0;
            if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
          end else begin
            crc_err <= 1'b1;
            r_fill  <= FILL_LAST;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end
        end
        default: ;
      endcase

      // A publish beats a same-cycle load; replacing an unread frame is an overrun.
      if (w_publish) begin
        frame_ready <= 1'b1;
        if (frame_ready && !load) overrun <= 1'b1;
      end else if (load) begin
        frame_ready <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frame_depack_p.md
FRAME_DEPACK_P -- requirements
Module: frame_depack_p

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 42, meaning total frame bytes including header and checksum; legal range 4..64.
REQ-002 SHALL have parameter HDR0, default 8'hEB, meaning first header byte.
REQ-003 SHALL have parameter HDR1, default 8'h90, meaning second header byte.
REQ-004 SHALL have parameter CSUM_MODE, default 0, meaning checksum type: 0 = 8-bit modulo-256 sum, 1 = 8-bit XOR.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid  input  1  byte-stream valid.
REQ-008 SHALL have port in_data  input  8  byte-stream data.
REQ-009 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high at a clock edge.
REQ-010 SHALL have port load  input  1  consumer acknowledge of the published frame.
REQ-011 SHALL have port frame_ready  output  1  a valid frame is published and unacknowledged.
REQ-012 SHALL have port frame_data  output  8*FRAME_LEN  published frame; byte k at bits [8*(FRAME_LEN-1-k) +: 8], byte 0 = HDR0.
REQ-013 SHALL have port crc_err  output  1  last header-matched window failed its checksum.
REQ-014 SHALL have port overrun  output  1  sticky: a published frame was replaced before load.
REQ-015 SHALL have port good_cnt  output  16  count of published frames, saturating at 16'hFFFF.
REQ-016 SHALL have port err_cnt  output  16  count of checksum failures, saturating at 16'hFFFF.

Function
REQ-017 SHALL hold a FRAME_LEN-byte sliding window; each accepted byte enters at index FRAME_LEN-1, all bytes shift toward index 0, and fill count increments, capped at FRAME_LEN.
REQ-018 SHALL implement states RX, HDR, SUM, CMP; in_ready SHALL be high only in RX.
REQ-019 RX: when fill count reaches FRAME_LEN, the next state SHALL be HDR.
REQ-020 HDR, one cycle: if window[0]==HDR0 and window[1]==HDR1, go to SUM with accumulator cleared; otherwise set fill count to FRAME_LEN-1 and return to RX, discarding the oldest byte.
REQ-021 SUM SHALL fold one byte per cycle, window[2]..window[FRAME_LEN-2], for FRAME_LEN-3 cycles, using the CSUM_MODE operation with carries discarded.
REQ-022 CMP, one cycle: on match, copy window to frame_data, set frame_ready, clear crc_err, increment good_cnt, clear fill count, and go to RX.
REQ-023 CMP, on mismatch: set crc_err, increment err_cnt, set fill count to FRAME_LEN-1 (resync by one byte), and go to RX; frame_data is unchanged.
REQ-024 frame_ready SHALL rise exactly FRAME_LEN-1 cycles after the edge accepting a frame's last byte.
REQ-025 load high SHALL clear frame_ready on the next edge; load with frame_ready low has no effect.
REQ-026 Publish while frame_ready=1 and load=0: frame_data is replaced, frame_ready stays 1, and overrun is set.
REQ-027 Publish and load in the same cycle: publish wins, frame_ready stays 1, and overrun is unchanged.
REQ-028 overrun SHALL clear only on reset.
REQ-029 in_valid during HDR/SUM/CMP SHALL NOT be accepted; the source holds the byte.

Reset
REQ-030 SHALL asynchronously on rst low: set state RX, fill count 0, accumulator 0, in_ready 1 (following state), frame_ready 0, crc_err 0, overrun 0, good_cnt 0, err_cnt 0, frame_data all zero, window all zero.
REQ-031 Reset mid-SUM SHALL abandon the window with no publish and no counter change.

Structure
REQ-032 Default header bytes, the CSUM_MODE encodings and the state encodings SHALL live in shared package depack_pkg.
REQ-033 The accumulate operation SHALL be sub-module frame_cksum (clear, enable, byte in, 8-bit result, mode parameter).

Verification
REQ-034 Clean frame EB 90, bytes 02..28, correct sum in byte 41 -> frame_ready at +41 cycles; good_cnt=1; crc_err=0; frame_data byte 2=8'h02.
REQ-035 Junk bytes 11 22 33 then a clean frame -> exactly one publish; good_cnt=1; err_cnt=0.
REQ-036 Correct frame with checksum byte XOR 8'h01 -> crc_err=1, err_cnt=1, no publish; a following good frame clears crc_err.
REQ-037 Two good frames without load -> overrun=1, frame_data = second frame; load and publish in the same cycle -> frame_ready stays 1.
REQ-038 CSUM_MODE=1, FRAME_LEN=8, payload 01 02 04 08 10, checksum 8'h1F -> publish at +7 cycles.
REQ-039 rst low during SUM -> all outputs return to reset values immediately; the next clean frame publishes normally.
